// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: T-state sequencer with Moore decode of step and IR opcode.
// Outputs follow the step register one cycle per step; clear forces RST and zeroes strobes asynchronously.
module control_sequencer #(
  parameter logic [4:0] ADD_OP  = 5'b00011,
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        InportOut,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        OutportIn,
  output logic [4:0]  opcode,
  output logic        Run
);

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;
  localparam logic [4:0] OP_JR  = 5'b10100;
  localparam logic [4:0] OP_IN  = 5'b10110;
  localparam logic [4:0] OP_OUT = 5'b10111;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } step_e;

  step_e step_q, step_d;

  logic [4:0] op;
  logic       is_ld, is_ldi, is_st, is_mem, is_alu;
  logic       ir_unused;

  assign op        = IR[31:27];
  assign ir_unused = ^IR[26:0];
  assign is_ld     = (op == OP_LD);
  assign is_ldi    = (op == OP_LDI);
  assign is_st     = (op == OP_ST);
  assign is_mem    = is_ld | is_ldi | is_st;
  assign is_alu    = (op >= 5'b00011) && (op <= 5'b00110);

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) step_q <= S_RST;
    else       step_q <= step_d;
  end

  always_comb begin
    step_d    = step_q;
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    Zin       = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    Cout      = 1'b0;
    InportOut = 1'b0;
    GRA       = 1'b0;
    GRB       = 1'b0;
    GRC       = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    OutportIn = 1'b0;
    opcode    = ADD_OP;
    Run       = 1'b1;

    unique case (step_q)
      S_RST: step_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        step_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        step_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        step_d = S_T3;
      end
      // IR has settled by T3; this is the only step that chooses the execute path.
      S_T3: begin
        step_d = S_T0;
        if (op == HALT_OP) begin
          step_d = S_HALT;
        end else if (is_mem) begin
          GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
          step_d = S_T4;
        end else if (is_alu) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
          step_d = S_T4;
        end else if (op == OP_JR) begin
          GRA = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end else if (op == OP_IN) begin
          InportOut = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end else if (op == OP_OUT) begin
          GRA = 1'b1; Rout = 1'b1; OutportIn = 1'b1;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        if (is_alu) begin
          GRC = 1'b1; Rout = 1'b1; opcode = op;
        end else begin
          Cout = 1'b1;
        end
        step_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin = 1'b1;
          step_d = S_T6;
        end else begin
          GRA = 1'b1; Rin = 1'b1;
          step_d = S_T0;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_st) begin
          GRA = 1'b1; Rout = 1'b1;
        end else begin
          Read = 1'b1;
        end
        step_d = S_T7;
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end
        step_d = S_T0;
      end
      S_HALT: Run = 1'b0;
      default: step_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, randomized instructions against a microprogram model,
// and hand-written halt / mid-instruction clear sequences.
module tb_control_sequencer;

  localparam logic [4:0] ADD_OP  = 5'b00011;
  localparam logic [4:0] HALT_OP = 5'b11011;

  localparam logic [21:0] M_PCOUT  = 22'h000001;
  localparam logic [21:0] M_ZLO    = 22'h000002;
  localparam logic [21:0] M_ZHI    = 22'h000004;
  localparam logic [21:0] M_MDROUT = 22'h000008;
  localparam logic [21:0] M_MARIN  = 22'h000010;
  localparam logic [21:0] M_ZIN    = 22'h000020;
  localparam logic [21:0] M_PCIN   = 22'h000040;
  localparam logic [21:0] M_MDRIN  = 22'h000080;
  localparam logic [21:0] M_IRIN   = 22'h000100;
  localparam logic [21:0] M_YIN    = 22'h000200;
  localparam logic [21:0] M_RIN    = 22'h000400;
  localparam logic [21:0] M_ROUT   = 22'h000800;
  localparam logic [21:0] M_BAOUT  = 22'h001000;
  localparam logic [21:0] M_COUT   = 22'h002000;
  localparam logic [21:0] M_INPORT = 22'h004000;
  localparam logic [21:0] M_GRA    = 22'h008000;
  localparam logic [21:0] M_GRB    = 22'h010000;
  localparam logic [21:0] M_GRC    = 22'h020000;
  localparam logic [21:0] M_INCPC  = 22'h040000;
  localparam logic [21:0] M_READ   = 22'h080000;
  localparam logic [21:0] M_WRITE  = 22'h100000;
  localparam logic [21:0] M_OUTIN  = 22'h200000;
  localparam logic [21:0] M_BUS    = M_PCOUT | M_ZLO | M_ZHI | M_MDROUT | M_ROUT | M_BAOUT | M_COUT | M_INPORT;

  logic Clock = 1'b0;
  logic clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic Rout, BAout, Cout, InportOut, GRA, GRB, GRC, IncPC, Read, Write, OutportIn, Run;
  logic [4:0] opcode;

  always #5 Clock = ~Clock;

  control_sequencer #(.ADD_OP(ADD_OP), .HALT_OP(HALT_OP)) dut (
    .Clock(Clock), .clear(clear), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .InportOut(InportOut),
    .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .IncPC(IncPC), .Read(Read), .Write(Write), .OutportIn(OutportIn),
    .opcode(opcode), .Run(Run)
  );

  typedef struct packed {
    logic [21:0] s;
    logic [4:0]  op;
    logic        run;
  } ctrl_t;

  typedef struct {
    logic [31:0] ir;
    int          cycles;
    int          key;
    logic [21:0] key_s;
    logic [4:0]  key_op;
  } vec_t;

  int total = 0;
  int bad   = 0;
  ctrl_t exp_q[$];
  ctrl_t obs_q[$];
  vec_t  tbl[13];

  function automatic ctrl_t mk(input logic [21:0] s, input logic [4:0] op, input logic run);
    ctrl_t w;
    w.s = s; w.op = op; w.run = run;
    return w;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t w;
    w.s = {OutportIn, Write, Read, IncPC, GRC, GRB, GRA, InportOut, Cout, BAout, Rout,
           Rin, Yin, IRin, MDRin, PCin, Zin, MARin, MDRout, Zhighout, Zlowout, PCout};
    w.op  = opcode;
    w.run = Run;
    return w;
  endfunction

  task automatic chk(input string name, input ctrl_t got, input ctrl_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got strobes=%h opcode=%b Run=%b, want strobes=%h opcode=%b Run=%b",
               name, got.s, got.op, got.run, want.s, want.op, want.run);
    end
  endtask

  task automatic chk_excl(input string name, input ctrl_t got);
    total++;
    if ($countones(got.s & M_BUS) > 1 || (got.s[19] && got.s[20])) begin
      bad++;
      $display("FAIL %s exclusivity: strobes=%h bus=%h", name, got.s, got.s & M_BUS);
    end
  endtask

  // Microprogram of one whole instruction, fetch included, as a list of control words.
  task automatic build(input logic [4:0] op);
    exp_q.delete();
    exp_q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, ADD_OP, 1'b1));
    exp_q.push_back(mk(M_ZLO | M_PCIN | M_READ | M_MDRIN, ADD_OP, 1'b1));
    exp_q.push_back(mk(M_MDROUT | M_IRIN, ADD_OP, 1'b1));
    if (op inside {5'd0, 5'd1, 5'd2}) begin
      exp_q.push_back(mk(M_GRB | M_BAOUT | M_YIN, ADD_OP, 1'b1));
      exp_q.push_back(mk(M_COUT | M_ZIN, ADD_OP, 1'b1));
      if (op == 5'd1) begin
        exp_q.push_back(mk(M_ZLO | M_GRA | M_RIN, ADD_OP, 1'b1));
      end else begin
        exp_q.push_back(mk(M_ZLO | M_MARIN, ADD_OP, 1'b1));
        if (op == 5'd0) begin
          exp_q.push_back(mk(M_READ | M_MDRIN, ADD_OP, 1'b1));
          exp_q.push_back(mk(M_MDROUT | M_GRA | M_RIN, ADD_OP, 1'b1));
        end else begin
          exp_q.push_back(mk(M_GRA | M_ROUT | M_MDRIN, ADD_OP, 1'b1));
          exp_q.push_back(mk(M_WRITE, ADD_OP, 1'b1));
        end
      end
    end else if (op inside {[5'd3:5'd6]}) begin
      exp_q.push_back(mk(M_GRB | M_ROUT | M_YIN, ADD_OP, 1'b1));
      exp_q.push_back(mk(M_GRC | M_ROUT | M_ZIN, op, 1'b1));
      exp_q.push_back(mk(M_ZLO | M_GRA | M_RIN, ADD_OP, 1'b1));
    end else begin
      case (op)
        5'b10100: exp_q.push_back(mk(M_GRA | M_ROUT | M_PCIN, ADD_OP, 1'b1));
        5'b10110: exp_q.push_back(mk(M_INPORT | M_GRA | M_RIN, ADD_OP, 1'b1));
        5'b10111: exp_q.push_back(mk(M_GRA | M_ROUT | M_OUTIN, ADD_OP, 1'b1));
        default:  exp_q.push_back(mk(22'h0, ADD_OP, 1'b1));
      endcase
    end
  endtask

  // Runs n steps starting at the next edge; IR changes just after the edge that enters T0.
  task automatic exec(input logic [31:0] ir, input int n, input string name);
    ctrl_t w;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      if (i == 0) begin
        #1;
        IR = ir;
      end
      @(negedge Clock);
      w = sample();
      obs_q.push_back(w);
      chk_excl(name, w);
    end
  endtask

  task automatic exec_model(input logic [31:0] ir, input int n, input string name);
    build(ir[31:27]);
    exec(ir, n, name);
    for (int i = 0; i < n; i++) chk($sformatf("%s step%0d", name, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    ctrl_t rst_w;
    ctrl_t t0_w;
    logic [4:0] rop;
    logic [31:0] rir;

    rst_w = mk(22'h0, ADD_OP, 1'b1);
    t0_w  = mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, ADD_OP, 1'b1);

    tbl[0]  = '{32'h09000095, 6, 5, M_ZLO | M_GRA | M_RIN, ADD_OP};
    tbl[1]  = '{32'h01000095, 8, 6, M_READ | M_MDRIN, ADD_OP};
    tbl[2]  = '{32'h01000095, 8, 7, M_MDROUT | M_GRA | M_RIN, ADD_OP};
    tbl[3]  = '{32'h11000095, 8, 6, M_GRA | M_ROUT | M_MDRIN, ADD_OP};
    tbl[4]  = '{32'h11000095, 8, 7, M_WRITE, ADD_OP};
    tbl[5]  = '{32'h18918000, 6, 4, M_GRC | M_ROUT | M_ZIN, 5'b00011};
    tbl[6]  = '{32'h20918000, 6, 4, M_GRC | M_ROUT | M_ZIN, 5'b00100};
    tbl[7]  = '{32'h20918000, 6, 3, M_GRB | M_ROUT | M_YIN, ADD_OP};
    tbl[8]  = '{32'hA2000000, 4, 3, M_GRA | M_ROUT | M_PCIN, ADD_OP};
    tbl[9]  = '{32'hB0800000, 4, 3, M_INPORT | M_GRA | M_RIN, ADD_OP};
    tbl[10] = '{32'hB8800000, 4, 3, M_GRA | M_ROUT | M_OUTIN, ADD_OP};
    tbl[11] = '{32'hD0000000, 4, 3, 22'h0, ADD_OP};
    tbl[12] = '{32'h38000000, 4, 3, 22'h0, ADD_OP};

    repeat (2) @(negedge Clock);
    chk("reset state", sample(), rst_w);
    clear = 1'b0;

    // Step 0 of each entry must be T0, which also pins the length of the entry before it.
    for (int i = 0; i < 13; i++) begin
      exec(tbl[i].ir, tbl[i].cycles, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d t0", i), obs_q[0], t0_w);
      chk($sformatf("vec%0d key", i), obs_q[tbl[i].key], mk(tbl[i].key_s, tbl[i].key_op, 1'b1));
    end

    for (int k = 0; k < 200; k++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == HALT_OP) rop = 5'b11010;
      rir = {rop, 27'($urandom)};
      build(rop);
      exec_model(rir, exp_q.size(), "rand");
    end

    exec_model(32'hD8000000, 4, "halt");
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      chk($sformatf("halted%0d", k), sample(), mk(22'h0, ADD_OP, 1'b0));
    end
    clear = 1'b1;
    #1;
    chk("clear exits halt", sample(), rst_w);
    @(negedge Clock);
    clear = 1'b0;

    exec_model(32'h01000095, 7, "ld to T6");
    clear = 1'b1;
    #1;
    chk("clear mid ld T6", sample(), rst_w);
    @(negedge Clock);
    chk("held in reset", sample(), rst_w);
    clear = 1'b0;

    exec_model(32'h11000095, 8, "st after clear");
    clear = 1'b1;
    #1;
    chk("clear during Write", sample(), rst_w);
    @(negedge Clock);
    clear = 1'b0;

    exec_model(32'h09000095, 6, "ldi after clear");
    exec_model(32'hB8800000, 4, "out tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
